// File: rtl/turn_input_conditioner.sv
// Front end for the tail-light turn FSM: synchronises and debounces the turn
// switches, arbitrates them into exclusive latched requests, and paces steps with tick.
module turn_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 33_554_432
) (
  input  logic clk,
  input  logic reset,
  input  logic left_sw,
  input  logic right_sw,
  output logic left_req,
  output logic right_req,
  output logic tick
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TK_W = $clog2(TICK_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LEFT  = 2'b01,
    ST_RIGHT = 2'b10
  } state_t;

  // Channel index 0 is left, 1 is right.
  logic [1:0]      sw_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      deb_r;
  logic [DB_W-1:0] deb_cnt_r [2];
  logic [TK_W-1:0] tick_cnt_r;
  logic            tick_r;
  logic            db_l_s;
  logic            db_r_s;
  state_t          state_r;
  state_t          next_state_s;
  logic            left_req_s;
  logic            right_req_s;

  assign sw_s   = {right_sw, left_sw};
  assign db_l_s = deb_r[0];
  assign db_r_s = deb_r[1];

  // Two-flop synchroniser for both raw switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= sw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel debounce: a new level must persist for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DB_LAST) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DB_W'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Free-running step timer; tick is high the cycle after the counter wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b0;
    end else if (tick_cnt_r == TK_LAST) begin
      tick_cnt_r <= '0;
      tick_r     <= 1'b1;
    end else begin
      tick_cnt_r <= tick_cnt_r + TK_W'(1);
      tick_r     <= 1'b0;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Arbiter next state: the opposite switch cancels at once, release waits for tick.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (db_l_s && !db_r_s) begin
          next_state_s = ST_LEFT;
        end else if (db_r_s && !db_l_s) begin
          next_state_s = ST_RIGHT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LEFT: begin
        if (db_r_s) begin
          next_state_s = ST_IDLE;
        end else if (tick_r && !db_l_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_LEFT;
        end
      end
      ST_RIGHT: begin
        if (db_l_s) begin
          next_state_s = ST_IDLE;
        end else if (tick_r && !db_r_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RIGHT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Request decode; the unused encoding drives neither request.
  always_comb begin
    left_req_s  = 1'b0;
    right_req_s = 1'b0;
    case (state_r)
      ST_LEFT: begin
        left_req_s  = 1'b1;
        right_req_s = 1'b0;
      end
      ST_RIGHT: begin
        left_req_s  = 1'b0;
        right_req_s = 1'b1;
      end
      default: begin
        left_req_s  = 1'b0;
        right_req_s = 1'b0;
      end
    endcase
  end

  assign left_req  = left_req_s;
  assign right_req = right_req_s;
  assign tick      = tick_r;

endmodule
